// File: rtl/rv64g_pkg.sv
// Shared RV64G definitions: register count and the lock tracker's state/counter types.
package rv64g_pkg;

    localparam int NUM_REGS  = 32;
    localparam int LOCK_CNTW = 4;

    typedef enum logic [1:0] {
        LT_RUN,
        LT_DRAIN,
        LT_EXCL
    } lock_trk_state_e;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter.
// It holds at 0 and at its maximum value. Increment and decrement in the same cycle cancel out.
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic full_o,
    output logic empty_o
);

    logic [W-1:0] cnt_q;

    assign full_o  = (cnt_q == {W{1'b1}});
    assign empty_o = (cnt_q == '0);

    // Count register: clear has priority, then a one-sided inc/dec bounded at the limits.
    // NOTE: sequential state is written with <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_q <= cnt_q + W'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

endmodule

// File: rtl/reg_lock_tracker.sv
// Register lock bitmap and in-flight instruction tracker.
// It also sequences blocking instructions through three phases: drain, exclusive execution, resume.
module reg_lock_tracker
    import rv64g_pkg::*;
#(
    parameter int NR   = NUM_REGS,
    parameter int CNTW = LOCK_CNTW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_blocking_i,
    input  logic [NR-1:0]         issue_locks_i,
    input  logic                  wb_valid_i,
    input  logic [$clog2(NR)-1:0] wb_rd_i,
    output logic [NR-1:0]         locks_o,
    output logic                  issue_ready_o,
    output logic                  excl_o
);

    lock_trk_state_e state_q, state_d;
    logic [NR-1:0]   locks_q, locks_d;
    logic [NR-1:0]   clr_mask;
    logic            ready;
    logic            cnt_inc, cnt_dec, cnt_clr;
    logic            cnt_full, cnt_empty;

    sat_updown_cnt #(
        .W (CNTW)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .clr_i   (cnt_clr),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    // Next-state, bitmap update and outputs; everything here depends only on registered state and inputs.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d       = state_q;
        locks_d       = locks_q;
        locks_o       = locks_q;
        ready         = 1'b0;
        excl_o        = 1'b0;
        cnt_inc       = 1'b0;
        cnt_dec       = 1'b0;
        cnt_clr       = 1'b0;
        clr_mask      = wb_valid_i ? (NR'(1) << wb_rd_i) : '0;

        case (state_q)
            LT_RUN: begin
                ready   = !cnt_full;
                cnt_dec = wb_valid_i;
                locks_d = locks_q & ~clr_mask;
                if (issue_valid_i && ready) begin
                    if (issue_blocking_i) begin
                        state_d = LT_DRAIN;
                    end else begin
                        cnt_inc = 1'b1;
                        // The set is applied after the clear, so the issue wins on a shared bit.
                        locks_d = locks_d | issue_locks_i;
                    end
                end
                // Register 0 is never a real dependency.
                locks_d = locks_d & ~NR'(1);
            end
            LT_DRAIN: begin
                locks_o = '1;
                cnt_dec = wb_valid_i;
                locks_d = locks_q & ~clr_mask & ~NR'(1);
                if (cnt_empty) begin
                    state_d = LT_EXCL;
                end
            end
            LT_EXCL: begin
                locks_o = '1;
                excl_o  = 1'b1;
                // This writeback is the blocking instruction itself retiring.
                if (wb_valid_i) begin
                    state_d = LT_RUN;
                    locks_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = LT_RUN;
            end
        endcase

        issue_ready_o = ready;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LT_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock bitmap register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locks_q <= '0;
        end else begin
            locks_q <= locks_d;
        end
    end

endmodule
